// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a single shared slave bus.
// Each transaction completes on slave ready or is forced closed by a wait-cycle timeout.
module bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            m_valid,
  input  logic [2*AW-1:0]       m_addr,
  input  logic [2*DW-1:0]       m_wdata,
  input  logic [(2*DW/8)-1:0]   m_wstrb,
  output logic [1:0]            m_ready,
  output logic [1:0]            m_err,
  output logic [DW-1:0]         m_rdata,
  output logic                  s_valid,
  output logic [AW-1:0]         s_addr,
  output logic [DW-1:0]         s_wdata,
  output logic [(DW/8)-1:0]     s_wstrb,
  input  logic                  s_ready,
  input  logic [DW-1:0]         s_rdata
);

  localparam int          SW           = DW / 8;
  localparam logic [15:0] TIMEOUT_CNT  = 16'(TIMEOUT);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state;
  logic        owner;
  logic        rr_last;
  logic [15:0] wait_cnt;

  logic busy;
  logic done_ok;
  logic timed_out;

  assign busy      = (state == GRANT) || (state == WAIT);
  assign done_ok   = busy && s_ready;
  assign timed_out = busy && (wait_cnt == TIMEOUT_CNT) && !s_ready;

  // rr_last resets to 1 so master 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rr_last  <= 1'b1;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_valid) begin
            owner    <= (m_valid == 2'b11) ? ~rr_last : m_valid[1];
            wait_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT, WAIT: begin
          if (s_ready || (wait_cnt == TIMEOUT_CNT)) begin
            rr_last <= owner;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            state    <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The request is withdrawn in the timeout cycle; a late s_ready there still completes normally.
  always_comb begin
    s_valid = busy && (wait_cnt != TIMEOUT_CNT);
    s_addr  = owner ? m_addr[2*AW-1:AW]  : m_addr[AW-1:0];
    s_wdata = owner ? m_wdata[2*DW-1:DW] : m_wdata[DW-1:0];
    s_wstrb = owner ? m_wstrb[2*SW-1:SW] : m_wstrb[SW-1:0];
    m_ready = '0;
    m_err   = '0;
    m_rdata = '0;
    if (done_ok) begin
      m_ready[owner] = 1'b1;
      m_rdata        = s_rdata;
    end else if (timed_out) begin
      m_ready[owner] = 1'b1;
      m_err[owner]   = 1'b1;
      m_rdata        = DW'(TIMEOUT_DATA);
    end
  end

endmodule
